// File: rtl/n_down_counter.sv
// n_down_counter: multi-digit radix-N down counter with clamped preset load.
// Ports: clock/reset, clear, load+preset, count -> q, zero, bo, done pulse.
module n_down_counter #(
  parameter int RADIX  = 10,
  parameter int WIDTH  = 4,
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    load,
  input  logic [DIGITS*WIDTH-1:0] preset,
  input  logic                    count,
  output logic                    bo,
  output logic [DIGITS*WIDTH-1:0] q,
  output logic                    zero,
  output logic                    done
);

  localparam int N = DIGITS * WIDTH;
  localparam logic [WIDTH-1:0] MAXD = WIDTH'(RADIX - 1);
  localparam logic [WIDTH:0]   RAD  = (WIDTH+1)'(RADIX);
  localparam logic [N-1:0]     ONE  = N'(1);

  logic [N-1:0]     dec;
  logic [N-1:0]     pre;
  logic             brw;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] p;
  logic             dec_en;

  assign zero   = (q == '0);
  assign dec_en = count & ~reset & ~clear & ~load;
  assign bo     = dec_en & zero;

  // Borrow ripples up through digits that are currently zero.
  always_comb begin
    dec = q;
    brw = 1'b1;
    d   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      d = q[k*WIDTH +: WIDTH];
      if (brw)
        dec[k*WIDTH +: WIDTH] = (d == '0) ? MAXD : d - 1'b1;
      brw = brw & (d == '0);
    end
    if (zero && !WRAP)
      dec = q;
  end

  always_comb begin
    pre = '0;
    p   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      p = preset[k*WIDTH +: WIDTH];
      pre[k*WIDTH +: WIDTH] = ({1'b0, p} >= RAD) ? MAXD : p;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q    <= '0;
      done <= 1'b0;
    end else if (clear) begin
      q    <= '0;
      done <= 1'b0;
    end else if (load) begin
      q    <= pre;
      done <= 1'b0;
    end else if (count) begin
      q    <= dec;
      done <= (q == ONE);
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_n_down_counter.sv
// tb_n_down_counter: checks WRAP=1 and WRAP=0 counters against an integer
// model with directed steps followed by randomized traffic.
module tb_n_down_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       load  = 1'b0;
  logic [7:0] preset = '0;
  logic       count = 1'b0;

  logic       bo_w, zero_w, done_w;
  logic [7:0] q_w;
  logic       bo_h, zero_h, done_h;
  logic [7:0] q_h;

  int ncmp = 0;
  int nerr = 0;

  int  vw = 0, vh = 0;
  bit  dw = 0, dh = 0;
  bit  primed = 0;

  always #5 clock = ~clock;

  n_down_counter #(.RADIX(10), .WIDTH(4), .DIGITS(2), .WRAP(1'b1)) u_w (
    .clock(clock), .reset(reset), .clear(clear), .load(load),
    .preset(preset), .count(count),
    .bo(bo_w), .q(q_w), .zero(zero_w), .done(done_w)
  );

  n_down_counter #(.RADIX(10), .WIDTH(4), .DIGITS(2), .WRAP(1'b0)) u_h (
    .clock(clock), .reset(reset), .clear(clear), .load(load),
    .preset(preset), .count(count),
    .bo(bo_h), .q(q_h), .zero(zero_h), .done(done_h)
  );

  function automatic logic [7:0] enc(input int v);
    enc = {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int clampv(input logic [7:0] p);
    int lo, hi;
    lo = (p[3:0] > 9) ? 9 : int'(p[3:0]);
    hi = (p[7:4] > 9) ? 9 : int'(p[7:4]);
    clampv = hi * 10 + lo;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd(inout int v, inout bit d, input bit wrap);
    if (reset || clear) begin
      v = 0; d = 0;
    end else if (load) begin
      v = clampv(preset); d = 0;
    end else if (count) begin
      d = (v == 1);
      v = (v == 0) ? (wrap ? 99 : 0) : v - 1;
    end else begin
      d = 0;
    end
  endtask

  task automatic step(input bit r, input bit c, input bit l,
                      input logic [7:0] p, input bit cnt);
    bit en;
    @(negedge clock);
    reset = r; clear = c; load = l; preset = p; count = cnt;
    #1;
    en = cnt & ~r & ~c & ~l;
    if (primed) begin
      chk("bo_wrap", {7'b0, bo_w}, {7'b0, en & (vw == 0)});
      chk("bo_hold", {7'b0, bo_h}, {7'b0, en & (vh == 0)});
      chk("zero_wrap", {7'b0, zero_w}, {7'b0, vw == 0});
      chk("zero_hold", {7'b0, zero_h}, {7'b0, vh == 0});
    end
    @(posedge clock);
    upd(vw, dw, 1'b1);
    upd(vh, dh, 1'b0);
    if (r) primed = 1;
    #1;
    if (primed) begin
      chk("q_wrap", q_w, enc(vw));
      chk("q_hold", q_h, enc(vh));
      chk("done_wrap", {7'b0, done_w}, {7'b0, dw});
      chk("done_hold", {7'b0, done_h}, {7'b0, dh});
    end
  endtask

  initial begin
    int rr;
    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);
    chk("reset_q", q_w, 8'h00);
    chk("reset_zero", {7'b0, zero_w}, 8'h01);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00, 0);
    chk("idle_q", q_h, 8'h00);

    step(0, 0, 1, 8'h23, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 1);
    chk("borrow_19", q_w, 8'h19);

    step(0, 0, 1, 8'h03, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 1);
    chk("timer_hold_q", q_h, 8'h00);
    chk("timer_no_repulse", {7'b0, done_h}, 8'h00);

    step(0, 0, 1, 8'h00, 0);
    step(0, 0, 0, 8'h00, 1);
    chk("wrap_99", q_w, 8'h99);
    chk("wrap_no_done", {7'b0, done_w}, 8'h00);
    step(0, 0, 0, 8'h00, 1);
    chk("wrap_98", q_w, 8'h98);

    step(0, 0, 1, 8'hFC, 0);
    chk("clamp_99", q_w, 8'h99);
    step(0, 0, 1, 8'h50, 1);
    chk("load_wins", q_h, 8'h50);

    step(0, 0, 1, 8'h05, 0);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 1);
    step(0, 1, 0, 8'h00, 1);
    chk("clear_q", q_w, 8'h00);
    step(1, 0, 1, 8'h77, 0);
    chk("reset_over_load", q_h, 8'h00);

    for (int i = 0; i < 400; i++) begin
      rr = $urandom_range(0, 99);
      if (rr < 2)
        step(1, 0, 0, 8'($urandom), $urandom_range(0, 1));
      else if (rr < 6)
        step(0, 1, $urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1));
      else if (rr < 16)
        step(0, 0, 1, 8'($urandom), $urandom_range(0, 1));
      else if (rr < 20)
        step(0, 0, 1, 8'($urandom_range(0, 3)), 0);
      else if (rr < 85)
        step(0, 0, 0, 8'h00, 1);
      else
        step(0, 0, 0, 8'h00, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
